// File: rtl/word_asm_pkg.sv
// rtl/word_asm_pkg.sv - shared sizing constants and byte-count type for the word assembler
package word_asm_pkg;

  localparam int DEF_BYTE_W = 8;
  localparam int DEF_NBYTES = 4;
  localparam int DEF_WORD_W = DEF_BYTE_W * DEF_NBYTES;
  localparam int DEF_CNT_W  = (DEF_NBYTES > 1) ? $clog2(DEF_NBYTES) : 1;

  typedef logic [DEF_CNT_W-1:0] byte_cnt_t;

  // Byte position within a word -> physical lane index.
  function automatic int lane_of(input int idx, input bit little_endian, input int nbytes);
    return little_endian ? idx : (nbytes - 1 - idx);
  endfunction

endpackage

// File: rtl/byte_lane_sel.sv
// rtl/byte_lane_sel.sv - maps the byte count and lane order to a one-hot lane write enable
module byte_lane_sel
  import word_asm_pkg::*;
#(
  parameter int NBYTES        = DEF_NBYTES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter bit LITTLE_ENDIAN = 1'b0
) (
  input  logic [CNT_W-1:0]  cnt,
  output logic [NBYTES-1:0] lane_we
);

  // One-hot decode of the lane that the next accepted byte lands in.
  always_comb begin
    lane_we = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (lane_of(int'(cnt), LITTLE_ENDIAN, NBYTES) == i) begin
        lane_we[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs a byte stream into words; WORD_ASSEMBLER_LITTLE_ENDIAN_EN selects lane order
module word_assembler
  import word_asm_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int NBYTES = DEF_NBYTES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [BYTE_W*NBYTES-1:0] out_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [((NBYTES > 1) ? $clog2(NBYTES) : 1)-1:0] byte_cnt
);

  localparam int WORD_W = BYTE_W * NBYTES;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

`ifdef WORD_ASSEMBLER_LITTLE_ENDIAN_EN
  localparam bit LITTLE_ENDIAN = 1'b1;
`else
  localparam bit LITTLE_ENDIAN = 1'b0;
`endif

  logic [WORD_W-1:0] part_q;
  logic [WORD_W-1:0] word_next;
  logic [NBYTES-1:0] lane_we;
  logic              is_last;
  logic              accept;

  byte_lane_sel #(
    .NBYTES        (NBYTES),
    .CNT_W         (CNT_W),
    .LITTLE_ENDIAN (LITTLE_ENDIAN)
  ) u_lane_sel (
    .cnt     (byte_cnt),
    .lane_we (lane_we)
  );

  // Only the final byte of a word can stall, and only while an unconsumed word is held.
  assign is_last  = (byte_cnt == CNT_LAST);
  assign in_ready = !is_last || !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !clear;

  // Partial word with the incoming byte merged into its lane.
  always_comb begin
    word_next = part_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (lane_we[i]) begin
        word_next[i*BYTE_W +: BYTE_W] = in_data;
      end
    end
  end

  // Partial-word accumulator and byte counter; clear drops any byte offered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      part_q   <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      part_q   <= '0;
    end else if (accept) begin
      if (is_last) begin
        byte_cnt <= '0;
        part_q   <= '0;
      end else begin
        byte_cnt <= byte_cnt + CNT_W'(1);
        part_q   <= word_next;
      end
    end
  end

  // Output register: a completing word overwrites the slot even while it is being consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_word  <= '0;
      out_valid <= 1'b0;
    end else if (accept && is_last) begin
      out_word  <= word_next;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_word_assembler.sv
// tb/tb_word_assembler.sv - randomized and directed checks of word_assembler against a queue model
module tb_word_assembler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  byte_cnt;

  always #5 clk = ~clk;

  word_assembler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .byte_cnt  (byte_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: bytes of the word in progress, plus one held output word.
  int          mq[$];
  bit          m_ov = 1'b0;
  logic [31:0] m_ow = 32'h0;
  logic [31:0] got[$];

  function automatic logic [31:0] pack_word(input int b[$]);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < 4; k++) begin
`ifdef WORD_ASSEMBLER_LITTLE_ENDIAN_EN
      w = w | (32'(b[k]) << (8 * k));
`else
      w = w | (32'(b[k]) << (8 * (3 - k)));
`endif
    end
    return w;
  endfunction

  // Literal expectations are written big-endian and byte-swapped for the little-endian build.
  function automatic logic [31:0] lit(input logic [31:0] be);
`ifdef WORD_ASSEMBLER_LITTLE_ENDIAN_EN
    return {be[7:0], be[15:8], be[23:16], be[31:24]};
`else
    return be;
`endif
  endfunction

  function automatic bit exp_ready();
    return (mq.size() < 3) || !m_ov || out_ready;
  endfunction

  function automatic logic [31:0] got_at(input int i);
    if (got.size() > i) return got[i];
    return 32'hxxxxxxxx;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model update at each edge (reset acts immediately).
  always @(posedge clk or negedge rst_n) begin : mdl
    bit rdy;
    bit cons;
    bit nw;
    if (!rst_n) begin
      mq.delete();
      m_ov = 1'b0;
      m_ow = 32'h0;
    end else begin
      rdy  = exp_ready();
      cons = m_ov && out_ready;
      nw   = 1'b0;
      if (clear) begin
        mq.delete();
      end else if (in_valid && rdy) begin
        mq.push_back(int'(in_data));
        if (mq.size() == 4) begin
          m_ow = pack_word(mq);
          mq.delete();
          nw = 1'b1;
        end
      end
      if (nw) m_ov = 1'b1;
      else if (cons) m_ov = 1'b0;
    end
  end

  // Compare DUT against the model away from the active edge; log consumed words.
  always @(negedge clk) begin
    if (cyc > 1) begin
      chk("in_ready", 32'(in_ready), 32'(exp_ready()));
      chk("byte_cnt", 32'(byte_cnt), 32'(mq.size()));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) chk("out_word", out_word, m_ow);
      if (out_valid && out_ready) got.push_back(out_word);
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %h never accepted", b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    clear    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", out_word, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    idle(1);

    // Single word, one-cycle out_valid pulse right after byte 4.
    out_ready = 1'b1;
    got.delete();
    send(8'h01); send(8'h01); send(8'h01); send(8'h00);
    in_valid = 1'b0;
    chk("s030_ov_set", 32'(out_valid), 32'd1);
    chk("s030_word", out_word, lit(32'h01010100));
    @(posedge clk); #1;
    chk("s030_ov_clr", 32'(out_valid), 32'd0);
    idle(2);
    chk("s030_count", 32'(got.size()), 32'd1);

    // Back-to-back bytes at full rate.
    got.delete();
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(8'(8'h11 * (i + 1)));
    in_valid = 1'b0;
    chk("s031_cycles", 32'(cyc - c0), 32'd8);
    idle(2);
    chk("s031_count", 32'(got.size()), 32'd2);
    chk("s031_w0", got_at(0), lit(32'h11223344));
    chk("s031_w1", got_at(1), lit(32'h55667788));

    // Back-pressure on the final byte.
    out_ready = 1'b0;
    got.delete();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'hAA); send(8'hBB); send(8'hCC);
    in_valid = 1'b1;
    in_data  = 8'hDD;
    repeat (3) begin
      @(negedge clk);
      chk("s032_stall", 32'(in_ready), 32'd0);
      chk("s032_hold", out_word, lit(32'h01020304));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'hDD);
    in_valid = 1'b0;
    idle(2);
    chk("s032_count", 32'(got.size()), 32'd2);
    chk("s032_w0", got_at(0), lit(32'h01020304));
    chk("s032_w1", got_at(1), lit(32'hAABBCCDD));

    // Clear discards the partial word and the byte offered with it.
    got.delete();
    send(8'h12); send(8'h34);
    in_valid = 1'b1;
    in_data  = 8'h99;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("s033_cnt", 32'(byte_cnt), 32'd0);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    idle(3);
    chk("s033_count", 32'(got.size()), 32'd1);
    chk("s033_w0", got_at(0), lit(32'hDEADBEEF));

    // Asynchronous reset mid-word.
    out_ready = 1'b0;
    send(8'h01); send(8'h02);
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("s034_pre_cnt", 32'(byte_cnt), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("s034_cnt", 32'(byte_cnt), 32'd0);
    chk("s034_ov", 32'(out_valid), 32'd0);
    chk("s034_word", out_word, 32'h0);
    chk("s034_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    got.delete();
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    idle(3);
    chk("s034_count", 32'(got.size()), 32'd1);
    chk("s034_w0", got_at(0), lit(32'h05060708));

    // Lane order pin.
    got.delete();
    send(8'h00); send(8'h01); send(8'h01); send(8'h01);
    idle(3);
    chk("s035_w0", got_at(0), lit(32'h00010101));

    // Random traffic with back-pressure and occasional clear.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 31) == 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
